// File: rtl/serial_adder.sv
// serial_adder: bit-serial LSB-first adder (one sum/carry cell) with a start/busy/done handshake.
// Optional SERIAL_ADDER_SUB_EN adds a sub port: a-b via inverted B and carry-in of 1.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic accept;
    logic last_bit;
    logic bit_s;
    logic carry_n;
    logic b_inv;
    logic carry_init;

    assign accept   = start && (state_q != RUN);
    assign last_bit = (state_q == RUN) && (count_q == LAST);
    assign bit_s    = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
    assign carry_n  = (a_sr_q[0] & b_sr_q[0]) | (a_sr_q[0] & carry_q) | (b_sr_q[0] & carry_q);

`ifdef SERIAL_ADDER_SUB_EN
    assign b_inv      = sub;
    assign carry_init = sub;
`else
    assign b_inv      = 1'b0;
    assign carry_init = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (count_q == LAST) state_d = DONE;
            DONE:    state_d = start ? RUN : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        sum  = sum_q;
        cout = cout_q;
    end

    // Datapath: operands shift out LSB-first, result fills in from the MSB end.
    always_comb begin
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        carry_d = carry_q;
        count_d = count_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        if (accept) begin
            a_sr_d  = a;
            b_sr_d  = b_inv ? ~b : b;
            res_d   = '0;
            carry_d = carry_init;
            count_d = '0;
        end else if (state_q == RUN) begin
            a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
            b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
            res_d   = {bit_s, res_q[WIDTH-1:1]};
            carry_d = carry_n;
            count_d = count_q + CNT_W'(1);
            if (last_bit) begin
                sum_d  = {bit_s, res_q[WIDTH-1:1]};
                cout_d = carry_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            count_q <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            count_q <= count_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end
endmodule
